// File: rtl/shreg_pkg.sv
// Shared types for the sequenced shift register: shift mode encoding and FSM states.
package shreg_pkg;

    typedef enum logic [1:0] {
        SHR_LOGIC_R = 2'b00,
        SHR_LEFT    = 2'b01,
        SHR_ARITH_R = 2'b10,
        SHR_ROT_R   = 2'b11
    } shreg_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } shreg_state_t;

endpackage

// File: rtl/shreg_step.sv
// One-position shifter shared by manual and sequenced shifts; also yields the outgoing bit.
// Mode 11 rotates only when SHREG_ROTATE_EN is defined, otherwise it behaves as mode 00.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shreg_mode_t      mode,
    input  logic             shift_in,
    output logic [WIDTH-1:0] result,
    output logic             shift_out
);

    logic [WIDTH-2:0] upper;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_upper
            assign upper[gi] = value[gi+1];
        end
    endgenerate

    always_comb begin
        result = {shift_in, upper};
        case (mode)
            SHR_LEFT:    result = {value[WIDTH-2:0], shift_in};
            SHR_ARITH_R: result = {value[WIDTH-1], upper};
`ifdef SHREG_ROTATE_EN
            SHR_ROT_R:   result = {value[0], upper};
`endif
            default:     result = {shift_in, upper};
        endcase
    end

    assign shift_out = (mode == SHR_LEFT) ? value[WIDTH-1] : value[0];

endmodule

// File: rtl/shift_reg_seq.sv
// Width-configurable load/shift register with a built-in shift sequencer (Start/Busy/Done).
// State updates on the falling clock edge. Optional rotate mode: SHREG_ROTATE_EN.
module shift_reg_seq
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Shift,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [1:0]       Mode,
    input  logic             Shift_In,
    output logic             Busy,
    output logic             Done,
    output logic             Shift_Out,
    output logic [WIDTH-1:0] Data_Out
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    shreg_state_t     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    shreg_mode_t      mode_q, mode_d;

    shreg_mode_t      eff_mode;
    logic [CNT_W-1:0] cnt_clamped;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // The Mode input steers only idle shifts; a running sequence uses its latched copy.
    assign eff_mode    = (state_q == IDLE) ? shreg_mode_t'(Mode) : mode_q;
    assign cnt_clamped = (Count > WIDTH_C) ? WIDTH_C : Count;

    shreg_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value    (data_q),
        .mode     (eff_mode),
        .shift_in (Shift_In),
        .result   (step_val),
        .shift_out(step_out)
    );

    always_ff @(negedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= SHR_LOGIC_R;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    data_d = D;
                end else if (Start) begin
                    if (cnt_clamped != '0) begin
                        mode_d  = shreg_mode_t'(Mode);
                        cnt_d   = cnt_clamped;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else if (Shift) begin
                    data_d = step_val;
                end
            end
            RUN: begin
                data_d = step_val;
                cnt_d  = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign Shift_Out = step_out;
    assign Data_Out  = data_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed self-checking bench for shift_reg_seq (WIDTH=8); expected values worked by hand.
module tb_shift_reg_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b1;
    logic             Reset, Load, Shift, Start, Shift_In;
    logic [WIDTH-1:0] D;
    logic [CNT_W-1:0] Count;
    logic [1:0]       Mode;
    logic             Busy, Done, Shift_Out;
    logic [WIDTH-1:0] Data_Out;

    int total = 0;
    int bad   = 0;

    shift_reg_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Load),
        .D        (D),
        .Shift    (Shift),
        .Start    (Start),
        .Count    (Count),
        .Mode     (Mode),
        .Shift_In (Shift_In),
        .Busy     (Busy),
        .Done     (Done),
        .Shift_Out(Shift_Out),
        .Data_Out (Data_Out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance past one active (falling) edge and settle before sampling.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        Load = 1'b1;
        D    = val;
        tick();
        Load = 1'b0;
    endtask

    // Start a sequence and follow it to Done; checks Busy length, final data and single Done pulse.
    task automatic run_seq(input string tag, input logic [CNT_W-1:0] cnt, input logic [1:0] md,
                           input logic sin, input logic [WIDTH-1:0] exp_data, input int exp_busy);
        int busy_n = 0;
        int done_n = 0;
        bit seen   = 1'b0;
        Count    = cnt;
        Mode     = md;
        Shift_In = sin;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                seen = 1'b1;
            end else begin
                tick();
            end
        end
        chk({tag, " seen_done"}, 32'(done_n), 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({tag, " data"}, 32'(Data_Out), 32'(exp_data));
        tick();
        chk({tag, " done_clear"}, 32'(Done), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; Shift = 1'b0; Start = 1'b0; Shift_In = 1'b0;
        D = '0; Count = '0; Mode = 2'b00;
        #2;
        tick();
        tick();
        Reset = 1'b0;
        chk("reset data", 32'(Data_Out), 32'h00);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);

        // Logical right, Shift_In=1, three shifts, checked edge by edge.
        load(8'hB4);
        chk("load B4", 32'(Data_Out), 32'hB4);
        Mode = 2'b00; Shift_In = 1'b1; Count = 4'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("lr E0 busy", 32'(Busy), 32'd1);
        chk("lr E0 data", 32'(Data_Out), 32'hB4);
        tick();
        chk("lr E1 data", 32'(Data_Out), 32'hDA);
        chk("lr E1 busy", 32'(Busy), 32'd1);
        tick();
        chk("lr E2 data", 32'(Data_Out), 32'hED);
        tick();
        chk("lr E3 data", 32'(Data_Out), 32'hF6);
        chk("lr E3 busy", 32'(Busy), 32'd0);
        chk("lr E3 done", 32'(Done), 32'd1);
        tick();
        chk("lr E4 done", 32'(Done), 32'd0);

        // Arithmetic right.
        load(8'h90);
        run_seq("arith", 4'd2, 2'b10, 1'b0, 8'hE4, 2);

        // Left shift; Shift_Out reflects the MSB before the shift.
        load(8'h81);
        Mode = 2'b01; Shift_In = 1'b0;
        #1;
        chk("left shift_out pre", 32'(Shift_Out), 32'd1);
        run_seq("left", 4'd1, 2'b01, 1'b0, 8'h02, 1);
        Mode = 2'b01;
        #1;
        chk("left shift_out post", 32'(Shift_Out), 32'd0);
        Mode = 2'b00;
        #1;
        chk("lr shift_out post", 32'(Shift_Out), 32'd0);

        // Mode 11 with Count=9 clamps to 8 shifts.
        load(8'h01);
`ifdef SHREG_ROTATE_EN
        run_seq("rot clamp", 4'd9, 2'b11, 1'b0, 8'h01, 8);
`else
        run_seq("rot clamp", 4'd9, 2'b11, 1'b0, 8'h00, 8);
`endif

        // Count = 0: immediate Done, no shift, no Busy.
        load(8'hA5);
        run_seq("count0", 4'd0, 2'b00, 1'b1, 8'hA5, 0);

        // Manual single shift in idle: left, Shift_In=1.
        load(8'h40);
        Mode = 2'b01; Shift_In = 1'b1; Shift = 1'b1;
        tick();
        Shift = 1'b0;
        chk("manual left", 32'(Data_Out), 32'h81);
        chk("manual busy", 32'(Busy), 32'd0);

        // Disturbances during RUN are ignored: 3C >> 4 with zeros = 03.
        load(8'h3C);
        Mode = 2'b00; Shift_In = 1'b0; Count = 4'd4; Start = 1'b1;
        tick();
        Load = 1'b1; D = 8'hFF; Shift = 1'b1; Mode = 2'b01;
        tick();
        tick();
        tick();
        tick();
        chk("disturb data", 32'(Data_Out), 32'h03);
        chk("disturb done", 32'(Done), 32'd1);
        tick();
        Load = 1'b0; Shift = 1'b0; Start = 1'b0; Mode = 2'b00;
        chk("disturb after done", 32'(Data_Out), 32'h03);
        chk("disturb idle done", 32'(Done), 32'd0);

        // Reset aborts a 5-shift run at its 2nd cycle.
        load(8'hFF);
        Mode = 2'b00; Shift_In = 1'b0; Count = 4'd5; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        chk("abort E1 data", 32'(Data_Out), 32'h7F);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort data", 32'(Data_Out), 32'h00);
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        begin
            int done_n = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (Done) done_n++;
            end
            chk("abort no done", 32'(done_n), 32'd0);
        end
        load(8'h0F);
        run_seq("after abort", 4'd2, 2'b01, 1'b1, 8'h3F, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised successor to the team's 8-bit load/shift register. Adds:
- configurable width;
- four shift modes;
- a built-in sequencer that performs a programmed number of shifts after a single Start, with Busy/Done handshake.

It sits beside the add/shift control logic in shift-and-add datapaths (multiplier, serial converters), so the controller no longer counts shifts itself. Manual single-step shifting is kept for existing controllers.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of Count
- Clk  in  1  clock; all state updates on falling edge
- Reset  in  1  reset Reset, synchronous, active-high
- Load  in  1  parallel load of D
- D  in  WIDTH  parallel load data
- Shift  in  1  manual single-position shift (idle only)
- Start  in  1  begin automatic sequence of Count shifts
- Count  in  CNT_W  number of shifts; values > WIDTH clamp to WIDTH
- Mode  in  2  00 logical right, 01 left, 10 arithmetic right, 11 rotate right
- Shift_In  in  1  serial input bit (modes 00, 01)
- Busy  out  1  sequence running
- Done  out  1  one-cycle pulse at sequence end
- Shift_Out  out  1  bit next leaving the register
- Data_Out  out  WIDTH  register contents

## Operation
- States: IDLE, RUN, DONE. Reset values: state IDLE, Data_Out 0, remaining count 0, latched mode 00, Busy 0, Done 0.
- IDLE priority: Reset > Load > Start > Shift.
  - Load: Data_Out ← D.
  - Start with clamped Count > 0: latch Mode and count, go to RUN.
  - Start with Count = 0: go to DONE, no shift.
  - Shift: one shift using the Mode input.
- RUN:
  - Each edge performs one shift using the latched mode and decrements the count.
  - The edge performing the last shift moves to DONE.
  - Load, Start, Shift and Mode changes are ignored.
- DONE: Done = 1; the next edge returns to IDLE. Load, Start and Shift are ignored for that cycle.
- Shift rules (n = WIDTH):
  - 00: {Shift_In, Data_Out[n-1:1]}
  - 01: {Data_Out[n-2:0], Shift_In}
  - 10: {Data_Out[n-1], Data_Out[n-1:1]}
  - 11: {Data_Out[0], Data_Out[n-1:1]}
- Shift_In is sampled every shifting edge, so a caller may stream bits during RUN.
- Shift_Out is combinational from the effective mode (latched mode in RUN/DONE, Mode input in IDLE):
  - Data_Out[WIDTH-1] for mode 01;
  - Data_Out[0] otherwise.
- Busy = (state == RUN); Done = (state == DONE). Both are registered state decodes, glitch-free.
- Reset in any state aborts: the next edge gives IDLE and Data_Out = 0, with no Done pulse.

## Timing
- Start sampled at edge E0 with clamped count N > 0:
  - shifts occur at E1..EN;
  - Busy is high from E0 to EN;
  - Done is high from EN to EN+1;
  - the next Start is accepted at EN+1.
- Count = 0: Done is high from E0 to E1; Busy stays low.
- Load and manual Shift take effect at the sampling edge; latency is 1 edge.
- Clamp: Count > WIDTH behaves exactly as Count = WIDTH.

## Configuration
- SHREG_ROTATE_EN defined: mode 11 rotates right as specified.
- Undefined: mode 11 decodes as mode 00 (logical right with Shift_In), and no rotate mux is built.

## Structure
- shreg_pkg holds:
  - typedef enum shreg_mode_t (SHR_LOGIC_R, SHR_LEFT, SHR_ARITH_R, SHR_ROT_R);
  - typedef enum shreg_state_t (IDLE, RUN, DONE).
- One combinational sub-module, shreg_step: takes value, mode and Shift_In, and returns the one-position shifted value and Shift_Out. Both manual and sequenced paths use it.
- The FSM, count and register live in shift_reg_seq.

## Test plan
- WIDTH=8. Load D=8'hB4, Mode=00, Shift_In=1, Start Count=3 → Data_Out DA, ED, F6 on successive edges; Busy high 3 cycles; Done one pulse.
- Load 8'h90, Mode=10, Count=2 → Data_Out=8'hE4. Load 8'h81, Mode=01, Shift_In=0, Count=1 → Shift_Out=1 before the shift; Data_Out=8'h02 after it.
- Load 8'h01, Mode=11, Count=9 → clamped to 8 shifts, Busy 8 cycles, Data_Out=8'h01 with SHREG_ROTATE_EN. Without the macro and with Shift_In=0 → Data_Out=8'h00.
- Start with Count=0 → Done pulses on the next cycle, Busy never rises, Data_Out unchanged.
- During RUN, pulse Load (D=8'hFF) and Shift, and change Mode → all ignored; result is identical to the undisturbed run.
- Assert Reset at the 2nd cycle of a 5-shift run → the next edge gives Data_Out=0, Busy=0, and no Done pulse; a fresh Start then works normally.
